// File: rtl/veggie_pkg.sv
// Shared definitions for the veggie slicing blocks.
// Holds screen/coordinate sizes, the tracker state encoding and small
// absolute-value helpers used by the cut-vector datapath.
package veggie_pkg;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int X_W      = 11;   // blade / veggie x coordinate width
    localparam int Y_W      = 10;   // blade / veggie y coordinate width
    localparam int BOUND_W  = 12;   // signed width of the box bound arithmetic

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSIDE = 2'd1,
        SPLIT  = 2'd2,
        GONE   = 2'd3
    } tracker_state_t;

    // Magnitude of a signed x difference; the result always fits X_W bits
    // because both operands are unsigned X_W-bit coordinates.
    function automatic logic [X_W-1:0] abs_x(input logic signed [X_W:0] d);
        logic signed [X_W:0] m;
        m = d[X_W] ? -d : d;
        return m[X_W-1:0];
    endfunction

    // Magnitude of a signed y difference.
    function automatic logic [Y_W-1:0] abs_y(input logic signed [Y_W:0] d);
        logic signed [Y_W:0] m;
        m = d[Y_W] ? -d : d;
        return m[Y_W-1:0];
    endfunction

endpackage

// File: rtl/box_hit.sv
// Registered point-in-box test with one cycle of latency.
// The box is centred on (cx_in, cy_in) and spans cx-WIDTH/2 .. cx+WIDTH/2-1
// horizontally (same for y with HEIGHT). Bounds are signed so a box hanging
// off the left/top screen edge does not wrap around.
// Ports:
//   clk_in      clock
//   rst_in      synchronous reset, active-high
//   valid_in    sample strobe
//   px_in/py_in point under test
//   cx_in/cy_in box centre
//   valid_out   registered strobe
//   inside_out  registered hit result (0 when valid_out is 0)
//   px_out/py_out registered copy of the point
module box_hit
    import veggie_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           valid_in,
    input  logic [X_W-1:0] px_in,
    input  logic [Y_W-1:0] py_in,
    input  logic [X_W-1:0] cx_in,
    input  logic [Y_W-1:0] cy_in,
    output logic           valid_out,
    output logic           inside_out,
    output logic [X_W-1:0] px_out,
    output logic [Y_W-1:0] py_out
);

    localparam logic signed [BOUND_W-1:0] HALF_W = BOUND_W'(WIDTH / 2);
    localparam logic signed [BOUND_W-1:0] HALF_H = BOUND_W'(HEIGHT / 2);

    logic signed [BOUND_W-1:0] w_px;
    logic signed [BOUND_W-1:0] w_py;
    logic signed [BOUND_W-1:0] w_cx;
    logic signed [BOUND_W-1:0] w_cy;
    logic signed [BOUND_W-1:0] w_x_lo;
    logic signed [BOUND_W-1:0] w_x_hi;
    logic signed [BOUND_W-1:0] w_y_lo;
    logic signed [BOUND_W-1:0] w_y_hi;
    logic                      w_inside;

    logic           r_valid;
    logic           r_inside;
    logic [X_W-1:0] r_px;
    logic [Y_W-1:0] r_py;

    // Zero-extend coordinates into the signed bound domain.
    assign w_px = $signed({1'b0, px_in});
    assign w_py = $signed({2'b00, py_in});
    assign w_cx = $signed({1'b0, cx_in});
    assign w_cy = $signed({2'b00, cy_in});

    assign w_x_lo = w_cx - HALF_W;
    assign w_x_hi = w_cx + HALF_W;
    assign w_y_lo = w_cy - HALF_H;
    assign w_y_hi = w_cy + HALF_H;

    // Upper bounds are exclusive so the box is exactly WIDTH x HEIGHT pixels.
    assign w_inside = (w_px >= w_x_lo) && (w_px < w_x_hi) &&
                      (w_py >= w_y_lo) && (w_py < w_y_hi);

    // Stage register for the sample and its hit result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid  <= 1'b0;
            r_inside <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
        end else begin
            r_valid  <= valid_in;
            r_inside <= valid_in & w_inside;
            r_px     <= px_in;
            r_py     <= py_in;
        end
    end

    assign valid_out  = r_valid;
    assign inside_out = r_inside;
    assign px_out     = r_px;
    assign py_out     = r_py;

endmodule

// File: rtl/slice_tracker.sv
// Converts per-frame blade samples into slice parameters for the split-sprite
// renderer. A swipe that enters the veggie box and later leaves it latches the
// cut vector (run/rise), drops intact_out and, GONE_FRAMES valid samples
// later, raises veggie_gone_out. Fixed 2-cycle latency from sample to outputs.
// Ports:
//   pixel_clk_in     clock
//   rst_in           synchronous reset, active-high
//   blade_x_in/y_in  blade position, qualified by blade_valid_in
//   x_in/y_in        veggie centre
//   new_veggie_in    re-arm pulse; wins over a simultaneous sample
//   intact_out       1 = whole sprite
//   run_out/rise_out cut vector magnitude, rise_neg_out = exit above entry
//   split_valid_out  one-cycle pulse on an accepted cut
//   veggie_gone_out  level, set GONE_FRAMES samples after the split
module slice_tracker
    import veggie_pkg::*;
#(
    parameter int WIDTH       = 256,
    parameter int HEIGHT      = 256,
    parameter int MIN_RUN     = 16,
    parameter int MAX_CUT     = 30,
    parameter int GONE_FRAMES = 60
) (
    input  logic           pixel_clk_in,
    input  logic           rst_in,
    input  logic [X_W-1:0] blade_x_in,
    input  logic [Y_W-1:0] blade_y_in,
    input  logic           blade_valid_in,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic           new_veggie_in,
    output logic           intact_out,
    output logic [X_W-1:0] run_out,
    output logic [Y_W-1:0] rise_out,
    output logic           rise_neg_out,
    output logic           split_valid_out,
    output logic           veggie_gone_out
);

    localparam int CNT_W = $clog2(MAX_CUT + 1);
    localparam int FRM_W = $clog2(GONE_FRAMES + 1);

    // Stage 1 results
    logic           w_sample_valid;
    logic           w_s1_valid;
    logic           w_s1_inside;
    logic [X_W-1:0] w_s1_x;
    logic [Y_W-1:0] w_s1_y;

    // Cut-vector datapath
    logic signed [X_W:0] w_dx;
    logic signed [Y_W:0] w_dy;
    logic [X_W-1:0]      w_adx;
    logic [Y_W-1:0]      w_ady;
    logic                w_too_short;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [FRM_W-1:0]    w_frm_inc;

    // State
    tracker_state_t   r_state;
    logic             r_prev_out;
    logic [X_W-1:0]   r_entry_x;
    logic [Y_W-1:0]   r_entry_y;
    logic [CNT_W-1:0] r_cnt;
    logic [FRM_W-1:0] r_frames;
    logic [X_W-1:0]   r_run;
    logic [Y_W-1:0]   r_rise;
    logic             r_rise_neg;
    logic             r_split_valid;
    logic             r_intact;
    logic             r_gone;

    // Next-state values
    tracker_state_t   w_state_nxt;
    logic             w_prev_out_nxt;
    logic [X_W-1:0]   w_entry_x_nxt;
    logic [Y_W-1:0]   w_entry_y_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [FRM_W-1:0] w_frames_nxt;
    logic [X_W-1:0]   w_run_nxt;
    logic [Y_W-1:0]   w_rise_nxt;
    logic             w_rise_neg_nxt;
    logic             w_split_valid_nxt;
    logic             w_intact_nxt;
    logic             w_gone_nxt;

    // A sample coinciding with new_veggie_in is dropped before stage 1.
    assign w_sample_valid = blade_valid_in & ~new_veggie_in;

    box_hit #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_box_hit (
        .clk_in     (pixel_clk_in),
        .rst_in     (rst_in),
        .valid_in   (w_sample_valid),
        .px_in      (blade_x_in),
        .py_in      (blade_y_in),
        .cx_in      (x_in),
        .cy_in      (y_in),
        .valid_out  (w_s1_valid),
        .inside_out (w_s1_inside),
        .px_out     (w_s1_x),
        .py_out     (w_s1_y)
    );

    assign w_dx        = $signed({1'b0, w_s1_x}) - $signed({1'b0, r_entry_x});
    assign w_dy        = $signed({1'b0, w_s1_y}) - $signed({1'b0, r_entry_y});
    assign w_adx       = abs_x(w_dx);
    assign w_ady       = abs_y(w_dy);
    assign w_too_short = (w_adx < X_W'(MIN_RUN)) && (w_ady < Y_W'(MIN_RUN));
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_frm_inc   = r_frames + FRM_W'(1);

    // State and datapath registers.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state       <= IDLE;
            r_prev_out    <= 1'b0;
            r_entry_x     <= '0;
            r_entry_y     <= '0;
            r_cnt         <= '0;
            r_frames      <= '0;
            r_run         <= X_W'(1);
            r_rise        <= '0;
            r_rise_neg    <= 1'b0;
            r_split_valid <= 1'b0;
            r_intact      <= 1'b1;
            r_gone        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_out    <= w_prev_out_nxt;
            r_entry_x     <= w_entry_x_nxt;
            r_entry_y     <= w_entry_y_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frames      <= w_frames_nxt;
            r_run         <= w_run_nxt;
            r_rise        <= w_rise_nxt;
            r_rise_neg    <= w_rise_neg_nxt;
            r_split_valid <= w_split_valid_nxt;
            r_intact      <= w_intact_nxt;
            r_gone        <= w_gone_nxt;
        end
    end

    // Next-state logic: new_veggie_in first, then the stage-1 sample.
    always_comb begin
        w_state_nxt       = r_state;
        w_prev_out_nxt    = r_prev_out;
        w_entry_x_nxt     = r_entry_x;
        w_entry_y_nxt     = r_entry_y;
        w_cnt_nxt         = r_cnt;
        w_frames_nxt      = r_frames;
        w_run_nxt         = r_run;
        w_rise_nxt        = r_rise;
        w_rise_neg_nxt    = r_rise_neg;
        w_split_valid_nxt = 1'b0;
        w_intact_nxt      = r_intact;
        w_gone_nxt        = r_gone;

        if (new_veggie_in) begin
            // Cut vector is kept; it is only looked at while intact_out=0.
            w_state_nxt    = IDLE;
            w_prev_out_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_frames_nxt   = '0;
            w_intact_nxt   = 1'b1;
            w_gone_nxt     = 1'b0;
        end else if (w_s1_valid) begin
            case (r_state)
                IDLE: begin
                    // Arming needs an outside sample followed by an inside one.
                    if (w_s1_inside && r_prev_out) begin
                        w_state_nxt   = INSIDE;
                        w_entry_x_nxt = w_s1_x;
                        w_entry_y_nxt = w_s1_y;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_prev_out_nxt = ~w_s1_inside;
                    end
                end
                INSIDE: begin
                    if (w_s1_inside) begin
                        // Dwelling too long aborts; prev_out=0 forces a fresh exit.
                        if (w_cnt_inc >= CNT_W'(MAX_CUT)) begin
                            w_state_nxt    = IDLE;
                            w_prev_out_nxt = 1'b0;
                            w_cnt_nxt      = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_too_short) begin
                        // A poke in and out counts as an outside sample for re-arming.
                        w_state_nxt    = IDLE;
                        w_prev_out_nxt = 1'b1;
                    end else begin
                        w_state_nxt       = SPLIT;
                        w_run_nxt         = (w_adx == '0) ? X_W'(1) : w_adx;
                        w_rise_nxt        = w_ady;
                        w_rise_neg_nxt    = w_dy[Y_W];
                        w_split_valid_nxt = 1'b1;
                        w_intact_nxt      = 1'b0;
                        w_frames_nxt      = '0;
                    end
                end
                SPLIT: begin
                    if (w_frm_inc == FRM_W'(GONE_FRAMES)) begin
                        w_state_nxt  = GONE;
                        w_gone_nxt   = 1'b1;
                        w_frames_nxt = w_frm_inc;
                    end else begin
                        w_frames_nxt = w_frm_inc;
                    end
                end
                GONE: begin
                    w_state_nxt = GONE;
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_prev_out_nxt = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        intact_out      = r_intact;
        run_out         = r_run;
        rise_out        = r_rise;
        rise_neg_out    = r_rise_neg;
        split_valid_out = r_split_valid;
        veggie_gone_out = r_gone;
    end

endmodule
